// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM state values and the default multiply latency.
package mdu_pkg;

  localparam logic [3:0] MDU_OP_NONE  = 4'd0;
  localparam logic [3:0] MDU_OP_MULT  = 4'd1;
  localparam logic [3:0] MDU_OP_MULTU = 4'd2;
  localparam logic [3:0] MDU_OP_DIV   = 4'd3;
  localparam logic [3:0] MDU_OP_DIVU  = 4'd4;
  localparam logic [3:0] MDU_OP_MTHI  = 4'd5;
  localparam logic [3:0] MDU_OP_MTLO  = 4'd6;
  localparam logic [3:0] MDU_OP_MADD  = 4'd7;
  localparam logic [3:0] MDU_OP_MADDU = 4'd8;
  localparam logic [3:0] MDU_OP_MSUB  = 4'd9;
  localparam logic [3:0] MDU_OP_MSUBU = 4'd10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam int MDU_MUL_LAT_DEFAULT = 5;

  typedef enum logic [1:0] {
    ACC_SET = 2'd0,
    ACC_ADD = 2'd1,
    ACC_SUB = 2'd2
  } acc_mode_e;

endpackage

// File: rtl/mdu_div_serial.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step.
// quot_o/rem_o show the result of the step in progress so the owner can commit on the last step.
module mdu_div_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH-1:0] rem_q, quot_q, dvsr_q;
  logic [WIDTH:0]   shifted, diff;
  logic             fits;

  // Partial remainder stays below the divisor, so one extra bit holds the trial subtract.
  assign shifted = {rem_q, quot_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr_q};
  assign fits    = ~diff[WIDTH];
  assign rem_o   = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quot_o  = {quot_q[WIDTH-2:0], fits};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
    end else if (load_i) begin
      rem_q  <= '0;
      quot_q <= dividend_i;
      dvsr_q <= divisor_i;
    end else if (step_i) begin
      rem_q  <= rem_o;
      quot_q <= quot_o;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Multiply/divide unit with fixed multiply latency, serial divider and pipeline cancel.
// state   | meaning
// ST_IDLE | ready for issue; mthi/mtlo complete here
// ST_MUL  | product held in shadow, counting down to commit
// ST_DIV  | serial divide running, one quotient bit per cycle
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = MDU_MUL_LAT_DEFAULT,
  parameter int DIV_LAT = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] MDU_i_Operand1,
  input  logic [WIDTH-1:0] MDU_i_Operand2,
  input  logic [3:0]       MDU_i_Operation,
  input  logic             MDU_i_Start,
  input  logic             MDU_i_Cancel,
  output logic             MDU_o_Busy,
  output logic [WIDTH-1:0] MDU_o_Hi,
  output logic [WIDTH-1:0] MDU_o_Lo
);

  localparam int CNT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  acc_mode_e          acc_q, acc_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic               is_mul, sgn_mul, is_div, sgn_div, op1_neg, op2_neg, div_load;
  logic [WIDTH-1:0]   mag1, mag2, div_quot, div_rem, quot_fix, rem_fix;
  logic [2*WIDTH-1:0] ext1, ext2, product, acc_sum, acc_dif;

  always_comb begin
    is_mul  = 1'b0;
    sgn_mul = 1'b0;
    is_div  = 1'b0;
    sgn_div = 1'b0;
    case (MDU_i_Operation)
      MDU_OP_MULT, MDU_OP_MADD, MDU_OP_MSUB: begin
        is_mul  = 1'b1;
        sgn_mul = 1'b1;
      end
      MDU_OP_MULTU, MDU_OP_MADDU, MDU_OP_MSUBU: is_mul = 1'b1;
      MDU_OP_DIV: begin
        is_div  = 1'b1;
        sgn_div = 1'b1;
      end
      MDU_OP_DIVU: is_div = 1'b1;
      default: ;
    endcase
  end

  assign ext1    = {{WIDTH{sgn_mul & MDU_i_Operand1[WIDTH-1]}}, MDU_i_Operand1};
  assign ext2    = {{WIDTH{sgn_mul & MDU_i_Operand2[WIDTH-1]}}, MDU_i_Operand2};
  assign product = ext1 * ext2;
  assign acc_sum = {hi_q, lo_q} + prod_q;
  assign acc_dif = {hi_q, lo_q} - prod_q;

  assign op1_neg = sgn_div & MDU_i_Operand1[WIDTH-1];
  assign op2_neg = sgn_div & MDU_i_Operand2[WIDTH-1];
  assign mag1    = op1_neg ? -MDU_i_Operand1 : MDU_i_Operand1;
  assign mag2    = op2_neg ? -MDU_i_Operand2 : MDU_i_Operand2;
  assign quot_fix = qneg_q ? -div_quot : div_quot;
  assign rem_fix  = rneg_q ? -div_rem  : div_rem;

  mdu_div_serial #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .reset      (reset),
    .load_i     (div_load),
    .step_i     (state_q == ST_DIV),
    .dividend_i (mag1),
    .divisor_i  (mag2),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    div_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MDU_i_Start && !MDU_i_Cancel) begin
          if (is_mul) begin
            state_d = ST_MUL;
            cnt_d   = CW'(MUL_LAT);
            prod_d  = product;
            if (MDU_i_Operation == MDU_OP_MADD || MDU_i_Operation == MDU_OP_MADDU)
              acc_d = ACC_ADD;
            else if (MDU_i_Operation == MDU_OP_MSUB || MDU_i_Operation == MDU_OP_MSUBU)
              acc_d = ACC_SUB;
            else
              acc_d = ACC_SET;
          end else if (is_div) begin
            state_d  = ST_DIV;
            cnt_d    = CW'(WIDTH);
            div_load = 1'b1;
            qneg_d   = op1_neg ^ op2_neg;
            rneg_d   = op1_neg;
            dz_d     = (MDU_i_Operand2 == '0);
          end else if (MDU_i_Operation == MDU_OP_MTHI) begin
            hi_d = MDU_i_Operand1;
          end else if (MDU_i_Operation == MDU_OP_MTLO) begin
            lo_d = MDU_i_Operand1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (MDU_i_Cancel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_IDLE;
            if (state_q == ST_MUL) begin
              case (acc_q)
                ACC_ADD: {hi_d, lo_d} = acc_sum;
                ACC_SUB: {hi_d, lo_d} = acc_dif;
                default: {hi_d, lo_d} = prod_q;
              endcase
            end else if (!dz_q) begin
              lo_d = quot_fix;
              hi_d = rem_fix;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      acc_q   <= ACC_SET;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign MDU_o_Busy = (state_q != ST_IDLE);
  assign MDU_o_Hi   = hi_q;
  assign MDU_o_Lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: a 32-bit/latency-5 build and a 16-bit/latency-1 build share stimulus
// and are compared each cycle against a transaction-level arithmetic model.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] op1, op2;
  logic [3:0]  op;
  logic        start, cancel;
  logic        busy0, busy1;
  logic [31:0] hi0, lo0;
  logic [15:0] hi1, lo1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32), .MUL_LAT(5)) u0 (
    .clk(clk), .reset(rst_n),
    .MDU_i_Operand1(op1), .MDU_i_Operand2(op2), .MDU_i_Operation(op),
    .MDU_i_Start(start), .MDU_i_Cancel(cancel),
    .MDU_o_Busy(busy0), .MDU_o_Hi(hi0), .MDU_o_Lo(lo0)
  );

  mdu_iter #(.WIDTH(16), .MUL_LAT(1)) u1 (
    .clk(clk), .reset(rst_n),
    .MDU_i_Operand1(op1[15:0]), .MDU_i_Operand2(op2[15:0]), .MDU_i_Operation(op),
    .MDU_i_Start(start), .MDU_i_Cancel(cancel),
    .MDU_o_Busy(busy1), .MDU_o_Hi(hi1), .MDU_o_Lo(lo1)
  );

  // ---------------- reference model ----------------
  bit [63:0] m_hi[2], m_lo[2], m_a[2], m_b[2];
  bit [3:0]  m_op[2];
  int        m_rem[2];
  bit        m_busy[2];

  function automatic int wd(int d);
    return (d == 0) ? 32 : 16;
  endfunction

  function automatic int lat(int d);
    return (d == 0) ? 5 : 1;
  endfunction

  function automatic bit [63:0] mask(int n);
    return (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic bit [63:0] sx(bit [63:0] v, int n);
    return v[n-1] ? (v | ~mask(n)) : v;
  endfunction

  task automatic m_commit(int d);
    int        w;
    bit [63:0] m, a, b, p, acc, uq, ur;
    longint    sa, sb, q, r;
    w = wd(d);
    m = mask(w);
    a = m_a[d];
    b = m_b[d];
    case (m_op[d])
      4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10: begin
        if (m_op[d] == 4'd1 || m_op[d] == 4'd7 || m_op[d] == 4'd9) p = sx(a, w) * sx(b, w);
        else p = a * b;
        acc = (m_hi[d] << w) | m_lo[d];
        if (m_op[d] == 4'd7 || m_op[d] == 4'd8) acc = acc + p;
        else if (m_op[d] == 4'd9 || m_op[d] == 4'd10) acc = acc - p;
        else acc = p;
        acc = acc & mask(2 * w);
        m_hi[d] = (acc >> w) & m;
        m_lo[d] = acc & m;
      end
      4'd3: if (b != 0) begin
        sa = sx(a, w);
        sb = sx(b, w);
        q = sa / sb;
        r = sa % sb;
        uq = q;
        ur = r;
        m_lo[d] = uq & m;
        m_hi[d] = ur & m;
      end
      4'd4: if (b != 0) begin
        m_lo[d] = (a / b) & m;
        m_hi[d] = (a % b) & m;
      end
      default: ;
    endcase
  endtask

  task automatic m_edge(int d);
    bit [63:0] a, b;
    a = {32'd0, op1} & mask(wd(d));
    b = {32'd0, op2} & mask(wd(d));
    if (m_busy[d]) begin
      if (cancel) m_busy[d] = 1'b0;
      else begin
        m_rem[d] = m_rem[d] - 1;
        if (m_rem[d] == 0) begin
          m_commit(d);
          m_busy[d] = 1'b0;
        end
      end
    end else if (start && !cancel) begin
      case (op)
        4'd5: m_hi[d] = a;
        4'd6: m_lo[d] = a;
        4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10: begin
          m_busy[d] = 1'b1;
          m_rem[d] = lat(d);
        end
        4'd3, 4'd4: begin
          m_busy[d] = 1'b1;
          m_rem[d] = wd(d);
        end
        default: ;
      endcase
      m_op[d] = op;
      m_a[d] = a;
      m_b[d] = b;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_hi[d] = 0; m_lo[d] = 0; m_busy[d] = 0; m_rem[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) m_edge(d);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(string nm, bit [63:0] act, bit [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("busy32", {63'd0, busy0}, {63'd0, m_busy[0]});
      chk("hi32", {32'd0, hi0}, m_hi[0]);
      chk("lo32", {32'd0, lo0}, m_lo[0]);
      chk("busy16", {63'd0, busy1}, {63'd0, m_busy[1]});
      chk("hi16", {48'd0, hi1}, m_hi[1]);
      chk("lo16", {48'd0, lo1}, m_lo[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int n0, output int n1);
    @(negedge clk);
    op = o; op1 = a; op2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy0 && !busy1) return;
      if (busy0) n0++;
      if (busy1) n1++;
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL busy_timeout actual=still_busy required=idle_within_200 at %0t", $time);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_8000;
      5: return 32'h7FFF_FFFF;
      6: return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  int n0, n1;

  initial begin
    op = 4'd0; op1 = '0; op2 = '0; start = 1'b0; cancel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("rst_hi", {32'd0, hi0}, 64'd0);
    chk("rst_lo", {32'd0, lo0}, 64'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_op(4'd1, 32'd12345678, 32'd24691356, n0, n1);
    chk("mult_cycles32", n0, 5);
    chk("mult_cycles16", n1, 1);
    chk("mult_hi", {32'd0, hi0}, 64'h0001153E);
    chk("mult_lo", {32'd0, lo0}, 64'h1F186788);

    run_op(4'd2, 32'd12345678, 32'd24691356, n0, n1);
    chk("multu_hi", {32'd0, hi0}, 64'h0001153E);
    chk("multu_lo", {32'd0, lo0}, 64'h1F186788);

    run_op(4'd3, 32'hFF43_9EB2, 32'd126, n0, n1);
    chk("div_cycles32", n0, 32);
    chk("div_cycles16", n1, 16);
    chk("div_lo", {32'd0, lo0}, 64'hFFFE8143);
    chk("div_hi", {32'd0, hi0}, 64'hFFFFFFB8);

    run_op(4'd4, 32'd12345678, 32'd0, n0, n1);
    chk("divz_cycles32", n0, 32);
    chk("divz_lo", {32'd0, lo0}, 64'hFFFE8143);
    chk("divz_hi", {32'd0, hi0}, 64'hFFFFFFB8);

    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n0, n1);
    chk("divovf_lo", {32'd0, lo0}, 64'h80000000);
    chk("divovf_hi", {32'd0, hi0}, 64'h0);

    run_op(4'd5, 32'h0, 32'h0, n0, n1);
    chk("mthi_busy", n0, 0);
    run_op(4'd6, 32'hFFFF_FFFF, 32'h0, n0, n1);
    run_op(4'd8, 32'd1, 32'd1, n0, n1);
    chk("maddu_cycles", n0, 5);
    chk("maddu_hi", {32'd0, hi0}, 64'h1);
    chk("maddu_lo", {32'd0, lo0}, 64'h0);
    run_op(4'd9, 32'd1, 32'd1, n0, n1);
    chk("msub_hi", {32'd0, hi0}, 64'h0);
    chk("msub_lo", {32'd0, lo0}, 64'hFFFFFFFF);

    // cancel on busy cycle 10
    @(negedge clk);
    op = 4'd3; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel10_busy", {63'd0, busy0}, 64'd0);
    chk("cancel10_hi", {32'd0, hi0}, 64'h0);
    chk("cancel10_lo", {32'd0, lo0}, 64'hFFFFFFFF);

    // cancel on the commit cycle
    @(negedge clk);
    op = 4'd3; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (31) @(negedge clk);
    chk("last_cycle_busy", {63'd0, busy0}, 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_last_busy", {63'd0, busy0}, 64'd0);
    chk("cancel_last_hi", {32'd0, hi0}, 64'h0);
    chk("cancel_last_lo", {32'd0, lo0}, 64'hFFFFFFFF);

    // cancel with start suppresses mtlo
    op = 4'd6; op1 = 32'h1234; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = 4'd0;
    @(negedge clk);
    chk("cancel_mtlo_lo", {32'd0, lo0}, 64'hFFFFFFFF);

    // async reset mid-mult
    op = 4'd1; op1 = 32'd3; op2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_busy32", {63'd0, busy0}, 64'd0);
    chk("rstmid_hi32", {32'd0, hi0}, 64'd0);
    chk("rstmid_lo32", {32'd0, lo0}, 64'd0);
    chk("rstmid_busy16", {63'd0, busy1}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 99) < 35);
      op     = 4'($urandom_range(0, 15));
      op1    = rnd_val();
      op2    = rnd_val();
      cancel = ($urandom_range(0, 99) < 3);
    end
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = 4'd0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
